// File: rtl/m_register_file.sv
// m_register_file: architectural register file plus write-back scoreboard.
// Defining MARISCAL_REGFILE_BYPASS_EN forwards write-back data to the read ports.

module m_register_file #(
   parameter int XLEN    = 32,
   parameter int NREGS   = 32,
   parameter bit R0_ZERO = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs_sel,
   output logic [XLEN-1:0]  rs_out,
   output logic             rs_ready,
   input  logic [4:0]       rq_sel,
   output logic [XLEN-1:0]  rq_out,
   output logic             rq_ready,
   input  logic             issue_valid,
   input  logic [4:0]       issue_rd,
   output logic             issue_ready,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   output logic [NREGS-1:0] busy,
   output logic [5:0]       pending_count
);

   localparam int MAX_REGS = 32;

   // Selects that address real, writable storage: in range, and not a hardwired r0.
   function automatic logic [MAX_REGS-1:0] tracked_mask();
      logic [MAX_REGS-1:0] m;
      for (int i = 0; i < MAX_REGS; i++)
         m[i] = (i < NREGS) && !(R0_ZERO && i == 0);
      return m;
   endfunction

   localparam logic [MAX_REGS-1:0] TRACKED = tracked_mask();

   logic [XLEN-1:0]     regs_q [MAX_REGS];
   logic [MAX_REGS-1:0] busy_q, busy_d;
   logic [5:0]          pending_q, pending_d;
   logic                wb_hit;
   logic                issue_acc;
   logic                rs_fwd, rq_fwd;

   assign wb_hit      = wb_valid && TRACKED[wb_rd];
   assign issue_ready = !busy_q[issue_rd] || (wb_valid && (wb_rd == issue_rd));
   assign issue_acc   = issue_valid && issue_ready && TRACKED[issue_rd];

   // NOTE: blocking '=' is correct here because this block only builds combinational next state.
   always_comb begin
      busy_d = busy_q;
      if (wb_hit)
         busy_d[wb_rd] = 1'b0;
      if (issue_acc)
         busy_d[issue_rd] = 1'b1;
   end

   assign pending_d = 6'($countones(busy_d));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q    <= '0;
         pending_q <= '0;
      end else begin
         busy_q    <= busy_d;
         pending_q <= pending_d;
      end
   end

   // NOTE: the array is reset because software relies on every register reading 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_REGS; i++)
            regs_q[i] <= '0;
      end else if (wb_hit) begin
         regs_q[wb_rd] <= wb_data;
      end
   end

`ifdef MARISCAL_REGFILE_BYPASS_EN
   assign rs_fwd = wb_hit && (wb_rd == rs_sel);
   assign rq_fwd = wb_hit && (wb_rd == rq_sel);
`else
   assign rs_fwd = 1'b0;
   assign rq_fwd = 1'b0;
`endif

   // NOTE: defaults first so every path assigns each output and no latch is inferred.
   always_comb begin
      rs_out   = '0;
      rs_ready = 1'b1;
      if (TRACKED[rs_sel]) begin
         if (rs_fwd) begin
            rs_out = wb_data;
         end else begin
            rs_out   = regs_q[rs_sel];
            rs_ready = !busy_q[rs_sel];
         end
      end
   end

   always_comb begin
      rq_out   = '0;
      rq_ready = 1'b1;
      if (TRACKED[rq_sel]) begin
         if (rq_fwd) begin
            rq_out = wb_data;
         end else begin
            rq_out   = regs_q[rq_sel];
            rq_ready = !busy_q[rq_sel];
         end
      end
   end

   assign busy          = busy_q[NREGS-1:0];
   assign pending_count = pending_q;

endmodule

// File: tb/tb_m_register_file.sv
// Scoreboard bench for m_register_file: two instances (R0_ZERO=0 and R0_ZERO=1) share
// stimulus; a behavioural model predicts outputs, a monitor compares at each falling edge.

module tb_m_register_file;

`ifdef MARISCAL_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] rs_out;
      logic        rs_ready;
      logic [31:0] rq_out;
      logic        rq_ready;
      logic        issue_ready;
      logic [31:0] busy;
      logic [5:0]  pend;
   } obs_t;

   typedef struct packed {
      logic [31:0] step;
      obs_t        o1;
      obs_t        o0;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs_sel, rq_sel, issue_rd, wb_rd;
   logic        issue_valid, wb_valid;
   logic [31:0] wb_data;

   logic [31:0] rs_out0, rq_out0, busy0, rs_out1, rq_out1, busy1;
   logic        rs_ready0, rq_ready0, issue_ready0, rs_ready1, rq_ready1, issue_ready1;
   logic [5:0]  pend0, pend1;

   m_register_file #(.XLEN(32), .NREGS(32), .R0_ZERO(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .rs_sel(rs_sel), .rs_out(rs_out0), .rs_ready(rs_ready0),
      .rq_sel(rq_sel), .rq_out(rq_out0), .rq_ready(rq_ready0),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready0),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .busy(busy0), .pending_count(pend0)
   );

   m_register_file #(.XLEN(32), .NREGS(32), .R0_ZERO(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .rs_sel(rs_sel), .rs_out(rs_out1), .rs_ready(rs_ready1),
      .rq_sel(rq_sel), .rq_out(rq_out1), .rq_ready(rq_ready1),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready1),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .busy(busy1), .pending_count(pend1)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int step     = 0;
   exp_t exp_q[$];

   // Reference model: plain arrays of register values and reservation flags per instance.
   logic [31:0] m_reg  [2][32];
   bit          m_busy [2][32];

   function automatic bit tracked(int k, int s);
      return !(k == 1 && s == 0);
   endfunction

   function automatic bit m_issue_ready(int k);
      return !m_busy[k][issue_rd] || (wb_valid && wb_rd == issue_rd);
   endfunction

   function automatic void m_read(int k, int s, output logic [31:0] d, output logic r);
      if (!tracked(k, s)) begin
         d = 32'd0; r = 1'b1;
      end else if (BYP && wb_valid && int'(wb_rd) == s) begin
         d = wb_data; r = 1'b1;
      end else begin
         d = m_reg[k][s]; r = !m_busy[k][s];
      end
   endfunction

   function automatic obs_t model_obs(int k);
      obs_t o;
      int   c = 0;
      m_read(k, int'(rs_sel), o.rs_out, o.rs_ready);
      m_read(k, int'(rq_sel), o.rq_out, o.rq_ready);
      o.issue_ready = m_issue_ready(k);
      for (int i = 0; i < 32; i++) begin
         o.busy[i] = m_busy[k][i];
         c += int'(m_busy[k][i]);
      end
      o.pend = 6'(c);
      return o;
   endfunction

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         automatic bit acc = issue_valid && m_issue_ready(k) && tracked(k, int'(issue_rd));
         if (wb_valid && tracked(k, int'(wb_rd))) begin
            m_reg[k][wb_rd]  = wb_data;
            m_busy[k][wb_rd] = 1'b0;
         end
         if (acc)
            m_busy[k][issue_rd] = 1'b1;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 32; i++) begin
            m_reg[k][i]  = 32'd0;
            m_busy[k][i] = 1'b0;
         end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req)
         n_pass++;
      else
         $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   function automatic obs_t dut_obs(int k);
      obs_t a;
      if (k == 0) begin
         a.rs_out = rs_out0; a.rs_ready = rs_ready0; a.rq_out = rq_out0; a.rq_ready = rq_ready0;
         a.issue_ready = issue_ready0; a.busy = busy0; a.pend = pend0;
      end else begin
         a.rs_out = rs_out1; a.rs_ready = rs_ready1; a.rq_out = rq_out1; a.rq_ready = rq_ready1;
         a.issue_ready = issue_ready1; a.busy = busy1; a.pend = pend1;
      end
      return a;
   endfunction

   task automatic compare(input int k, input obs_t e, input logic [31:0] s);
      obs_t a = dut_obs(k);
      string p = $sformatf("step%0d dut%0d", s, k);
      check({p, " rs_out"},      64'(a.rs_out),      64'(e.rs_out));
      check({p, " rs_ready"},    64'(a.rs_ready),    64'(e.rs_ready));
      check({p, " rq_out"},      64'(a.rq_out),      64'(e.rq_out));
      check({p, " rq_ready"},    64'(a.rq_ready),    64'(e.rq_ready));
      check({p, " issue_ready"}, 64'(a.issue_ready), 64'(e.issue_ready));
      check({p, " busy"},        64'(a.busy),        64'(e.busy));
      check({p, " pending"},     64'(a.pend),        64'(e.pend));
   endtask

   // Monitor: outputs are combinational or registered, so sample mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare(0, e.o0, e.step);
            compare(1, e.o1, e.step);
         end
      end
   end

   task automatic push_expect();
      exp_t e;
      e.step = 32'(step);
      e.o0   = model_obs(0);
      e.o1   = model_obs(1);
      exp_q.push_back(e);
      step++;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rq,
                        input logic iv, input logic [4:0] ird,
                        input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
      rs_sel = rs; rq_sel = rq;
      issue_valid = iv; issue_rd = ird;
      wb_valid = wv; wb_rd = wrd; wb_data = wd;
      push_expect();
      @(posedge clk);
      if (rst_n)
         model_edge();
      #1;
   endtask

   task automatic idle_read(input logic [4:0] rs, input logic [4:0] rq);
      drive(rs, rq, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
   endtask

   // Asserted just after an edge and checked before the next one: reset must act without a clock.
   task automatic apply_reset(input int cycles);
      rst_n = 1'b0;
      rs_sel = '0; rq_sel = '0; issue_valid = 1'b0; issue_rd = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
      model_reset();
      repeat (cycles) begin
         push_expect();
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst_n = 1'b1;
      rs_sel = '0; rq_sel = '0; issue_valid = 1'b0; issue_rd = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
      model_reset();
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      apply_reset(2);

      for (int i = 0; i < 32; i++) idle_read(5'(i), 5'(31 - i));
      for (int i = 0; i < 32; i++) drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(i), 32'(i));
      for (int i = 0; i < 32; i++) idle_read(5'(i), 5'(31 - i));
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
      idle_read(5'd5, 5'd5);

      drive(5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
      drive(5'd7, 5'd7, 1'b0, 5'd7, 1'b0, 5'd0, 32'd0);
      drive(5'd7, 5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 32'h1234);
      idle_read(5'd7, 5'd7);

      drive(5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0);
      drive(5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 32'h55);
      idle_read(5'd3, 5'd3);
      drive(5'd3, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h66);

      for (int i = 0; i < 32; i++) drive(5'(i), 5'd0, 1'b1, 5'(i), 1'b0, 5'd0, 32'd0);
      idle_read(5'd31, 5'd1);
      for (int i = 0; i < 32; i++) drive(5'(i), 5'(i), 1'b0, 5'd0, 1'b1, 5'(i), ~32'(i));
      for (int i = 1; i < 32; i++) begin
         if (i == 17) apply_reset(1);
         drive(5'(i), 5'd2, 1'b1, 5'(i), 1'b0, 5'd0, 32'd0);
      end
      apply_reset(1);

      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
      idle_read(5'd0, 5'd0);
      drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0);
      drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0);
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hA5A5A5A5);
      idle_read(5'd0, 5'd0);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            apply_reset(1);
         end else begin
            logic [4:0] ird, wrd, rs, rq;
            ird = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wrd = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rs  = ($urandom_range(0, 2) == 0) ? wrd : 5'($urandom_range(0, 31));
            rq  = ($urandom_range(0, 2) == 0) ? ird : 5'($urandom_range(0, 31));
            drive(rs, rq, 1'($urandom_range(0, 1)), ird,
                  1'($urandom_range(0, 2) != 0), wrd, 32'($urandom));
         end
      end

      t = 0;
      while (exp_q.size() > 0 && t < 5) begin
         @(posedge clk);
         t++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/m_register_file.md
Name: m_register_file

Overview:
- Architectural register file and write-back scoreboard on the far side of the decoder's operand-read interface.
- Returns operand data for the decoder's rs_sel/rq_sel selects.
- Reserves a destination register when an instruction issues, and releases it when write-back retires the result.
- Stalls issue on write-after-write hazards. Flags operands whose producer has not yet written back.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; select width is $clog2(NREGS) = 5 at default.
- R0_ZERO, 0, when 1, r0 reads as 0 and writes to it are discarded; r0 is never marked busy.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs_sel  input  5  operand A register select, driven by decoder.
- rs_out  output  XLEN  operand A data, to decoder rs_in.
- rs_ready  output  1  operand A data is current (no pending write).
- rq_sel  input  5  operand B register select.
- rq_out  output  XLEN  operand B data, to decoder rq_in.
- rq_ready  output  1  operand B data is current.
- issue_valid  input  1  instruction issuing with destination issue_rd.
- issue_rd  input  5  destination register to reserve.
- issue_ready  output  1  issue may be accepted this cycle.
- wb_valid  input  1  write-back strobe.
- wb_rd  input  5  write-back destination.
- wb_data  input  XLEN  write-back value.
- busy  output  NREGS  registered scoreboard; bit n set = rn has a pending write.
- pending_count  output  6  registered popcount of busy.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle including mid-operation):
  - all registers 0; busy 0; pending_count 0.
  - combinational outputs then reflect that state: rs_out/rq_out 0, rs_ready/rq_ready 1, issue_ready 1.
  - In-flight reservations are dropped; a later wb to a non-busy register still writes.
- Reads are combinational, 0-cycle latency.
  - rs_out = reg[rs_sel]; rs_ready = !busy[rs_sel]. rq identical.
  - Both ports may select the same register.
- Write: on clk edge with wb_valid, reg[wb_rd] <= wb_data and busy[wb_rd] <= 0.
  - A write to a non-busy register is legal and writes the data; busy is unchanged.
- Issue handshake:
  - Accepted = issue_valid && issue_ready.
  - issue_ready = !busy[issue_rd] || (wb_valid && wb_rd == issue_rd).
  - On accept, busy[issue_rd] <= 1.
  - issue_ready does not depend on issue_valid.
- Simultaneous accepted issue and wb to the same register: data is written and busy ends 1 (set wins over clear).
- Simultaneous issue and wb to different registers: both take effect.
- pending_count is updated in the same edge from the next-state busy vector, so it always equals popcount(busy); maximum 32, no wrap.
- R0_ZERO=1:
  - reads of r0 return 0 with ready 1.
  - wb to r0 is ignored.
  - issue to r0 is always ready and sets no bit.
- Select values >= NREGS (only possible when NREGS < 32):
  - reads return 0, ready 1.
  - writes and issues are ignored.

Optional Feature:
- Macro: MARISCAL_REGFILE_BYPASS_EN.
- Defined: write-back forwarding.
  - If wb_valid && wb_rd == rs_sel (excluding r0 when R0_ZERO), rs_out = wb_data and rs_ready = 1 in the same cycle. rq is handled identically.
  - The register array still updates on the edge.
- Undefined: no forwarding.
  - rs_out shows the old value and rs_ready = 0 during the write-back cycle.
  - New data and ready=1 appear the cycle after.

Test Plan:
- Reset release -> every select on rs/rq returns 0, ready 1; busy=0, pending_count=0, issue_ready=1.
- wb r5=0xDEADBEEF, next cycle rs_sel=5, rq_sel=5 -> both outputs 0xDEADBEEF, ready 1; repeat for all 32 registers with data=index.
- Issue rd=7; next cycle -> busy[7]=1, pending_count=1, issue_ready=0 for issue_rd=7, rs_ready=0 for rs_sel=7.
  - Then wb r7=0x1234 -> busy[7]=0 after edge; rs_out=0x1234.
  - Same-cycle check: without bypass rs_ready=0 during wb cycle; with bypass rs_out=0x1234 and ready=1 during wb cycle.
- Same cycle: busy r3, issue rd=3 and wb r3=0x55 -> issue accepted, reg3=0x55, busy[3] remains 1, pending_count unchanged.
- Issue rd=1..31 on consecutive cycles -> pending_count reaches 31 (32 including r0 when R0_ZERO=0). Assert rst_n low mid-sequence -> busy and pending_count 0 immediately, without waiting for a clock.
- R0_ZERO=1: wb r0=0xFFFFFFFF -> rs_sel=0 reads 0; issue rd=0 -> busy unchanged, issue_ready stays 1.
